// File: rtl/qos_pkg.sv
// ---------------------------------------------------------------------------
// qos_pkg
// Shared constants and types for the PCIe QoS virtual-channel scheduler.
//   NUM_VC : number of virtual channels (the scheduler supports exactly 4)
//   VC_W   : width of a VC index
//   WW     : width of a per-VC weight / credit
//   state_t: scheduler phase (INIT = configuration, RUN = scheduling)
// ---------------------------------------------------------------------------
package qos_pkg;

  localparam int NUM_VC = 4;
  localparam int VC_W   = 2;
  localparam int WW     = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : qos_pkg

// File: rtl/vc_wrr_scheduler_if.sv
// ---------------------------------------------------------------------------
// vc_wrr_scheduler_if
// Bundles the scheduler's FIFO-bank and output-buffer signals.
//   Set_init   : configuration phase, weights latched while high
//   Weight_cfg : per-VC weights, VC i at [WW*i +: WW]
//   Empty      : per-VC FIFO empty flags
//   Pause_stb  : per-VC level pause from the threshold logic
//   Pop_buffer : downstream ready
//   Pop_CF     : one-hot pop strobe to the VC FIFOs
//   VC_ID      : index of the granted VC
//   Valid      : a pop strobe is present this cycle
//   Idle       : running with every VC FIFO empty
// Modports: master (environment side), slave (scheduler side).
// ---------------------------------------------------------------------------
interface vc_wrr_scheduler_if;
  import qos_pkg::*;

  logic                   Set_init;
  logic [NUM_VC*WW-1:0]   Weight_cfg;
  logic [NUM_VC-1:0]      Empty;
  logic [NUM_VC-1:0]      Pause_stb;
  logic                   Pop_buffer;
  logic [NUM_VC-1:0]      Pop_CF;
  logic [VC_W-1:0]        VC_ID;
  logic                   Valid;
  logic                   Idle;

  modport master (
    output Set_init, Weight_cfg, Empty, Pause_stb, Pop_buffer,
    input  Pop_CF, VC_ID, Valid, Idle
  );

  modport slave (
    input  Set_init, Weight_cfg, Empty, Pause_stb, Pop_buffer,
    output Pop_CF, VC_ID, Valid, Idle
  );

endinterface : vc_wrr_scheduler_if

// File: rtl/vc_rr_picker.sv
// ---------------------------------------------------------------------------
// vc_rr_picker
// Combinational rotating-priority picker: returns the first set bit of
// eligible_i found searching upward from ptr_i, wrapping 3 -> 0.
//   eligible_i : request vector
//   ptr_i      : highest-priority position
//   grant_o    : one-hot grant (zero when nothing is eligible)
//   idx_o      : index of the granted position
//   any_o      : at least one request present
// ---------------------------------------------------------------------------
module vc_rr_picker
  import qos_pkg::*;
(
  input  logic [NUM_VC-1:0] eligible_i,
  input  logic [VC_W-1:0]   ptr_i,
  output logic [NUM_VC-1:0] grant_o,
  output logic [VC_W-1:0]   idx_o,
  output logic              any_o
);

  logic [2*NUM_VC-1:0] dbl;
  logic [NUM_VC-1:0]   rot;
  logic [VC_W-1:0]     off;

  // Doubling the vector lets a plain part-select perform the rotation:
  // rot[k] is the request at position (ptr + k) mod NUM_VC.
  assign dbl = {eligible_i, eligible_i};
  assign rot = dbl[{1'b0, ptr_i} +: NUM_VC];

  always_comb begin
    off = '0;
    for (int k = NUM_VC - 1; k >= 0; k--) begin
      if (rot[k]) off = VC_W'(k);
    end
  end

  assign any_o   = |rot;
  assign idx_o   = ptr_i + off;  // wraps naturally in VC_W bits
  assign grant_o = any_o ? (NUM_VC'(1) << idx_o) : '0;

endmodule : vc_rr_picker

// File: rtl/vc_wrr_scheduler.sv
// ---------------------------------------------------------------------------
// vc_wrr_scheduler
// Weighted round-robin pop scheduler for the four VC FIFOs. Each VC may be
// popped up to its weight per round; a round ends with a one-cycle reload
// bubble when no VC can be served but some VC still has data.
//   CLK   : clock, rising edge
//   Reset : synchronous active-high reset
//   bus   : vc_wrr_scheduler_if.slave (config, FIFO flags, ready, strobes)
// Optional build macro STRICT_VC3_EN: VC3 becomes strict priority and
// bypasses credits; VC0..2 keep weighted round-robin among themselves.
// ---------------------------------------------------------------------------
module vc_wrr_scheduler
  import qos_pkg::*;
(
  input logic               CLK,
  input logic               Reset,
  vc_wrr_scheduler_if.slave bus
);

`ifdef STRICT_VC3_EN
  localparam bit STRICT_VC3 = 1'b1;
`else
  localparam bit STRICT_VC3 = 1'b0;
`endif

  state_t                     state_q, state_d;
  logic [NUM_VC-1:0][WW-1:0]  weight_q, weight_d;
  logic [NUM_VC-1:0][WW-1:0]  credit_q, credit_d;
  logic [VC_W-1:0]            ptr_q, ptr_d;
  logic [NUM_VC-1:0]          pop_cf_q, pop_cf_d;
  logic [VC_W-1:0]            vc_id_q, vc_id_d;
  logic                       valid_q, valid_d;
  logic                       idle_q, idle_d;

  logic [NUM_VC-1:0]          eligible;
  logic [NUM_VC-1:0]          live;      // could be served after a reload
  logic [NUM_VC-1:0]          pick_grant;
  logic [VC_W-1:0]            pick_idx;
  logic                       pick_any;
  logic                       vc3_strict;

  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_elig
    if (STRICT_VC3 && gi == NUM_VC - 1) begin : g_strict
      // The strict VC never takes part in the weighted rounds.
      assign live[gi]     = 1'b0;
      assign eligible[gi] = 1'b0;
    end else begin : g_wrr
      assign live[gi]     = ~bus.Empty[gi] & ~bus.Pause_stb[gi] & (|weight_q[gi]);
      assign eligible[gi] = live[gi] & (|credit_q[gi]);
    end
  end

  assign vc3_strict = STRICT_VC3 & ~bus.Empty[NUM_VC-1] & ~bus.Pause_stb[NUM_VC-1];

  vc_rr_picker u_picker (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (pick_grant),
    .idx_o      (pick_idx),
    .any_o      (pick_any)
  );

  always_comb begin
    weight_d = weight_q;
    credit_d = credit_q;
    ptr_d    = ptr_q;
    pop_cf_d = '0;
    vc_id_d  = vc_id_q;
    valid_d  = 1'b0;
    idle_d   = 1'b0;
    // Set_init high always means "configuring": it drops any decision and
    // leads to INIT on the next edge, whichever phase we are in.
    state_d  = bus.Set_init ? INIT : RUN;

    if (bus.Set_init) weight_d = bus.Weight_cfg;

    if (state_q == INIT || bus.Set_init) begin
      // Keep credits tracking the weights so RUN starts with a full round.
      credit_d = weight_d;
      vc_id_d  = '0;
    end else begin
      idle_d = &bus.Empty;
      if (bus.Pop_buffer) begin
        if (vc3_strict) begin
          pop_cf_d[NUM_VC-1] = 1'b1;
          vc_id_d            = VC_W'(NUM_VC - 1);
          valid_d            = 1'b1;
        end else if (pick_any) begin
          pop_cf_d           = pick_grant;
          vc_id_d            = pick_idx;
          valid_d            = 1'b1;
          credit_d[pick_idx] = credit_q[pick_idx] - 1'b1;
          // Stay on the VC while it has credit so its burst continues.
          ptr_d = (credit_q[pick_idx] == WW'(1)) ? pick_idx + 1'b1 : pick_idx;
        end else if (|live) begin
          // Round exhausted but data is waiting: refill, spend one bubble.
          credit_d = weight_q;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= INIT;
      weight_q <= '0;
      credit_q <= '0;
      ptr_q    <= '0;
      pop_cf_q <= '0;
      vc_id_q  <= '0;
      valid_q  <= 1'b0;
      idle_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      weight_q <= weight_d;
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
      pop_cf_q <= pop_cf_d;
      vc_id_q  <= vc_id_d;
      valid_q  <= valid_d;
      idle_q   <= idle_d;
    end
  end

  assign bus.Pop_CF = pop_cf_q;
  assign bus.VC_ID  = vc_id_q;
  assign bus.Valid  = valid_q;
  assign bus.Idle   = idle_q;

endmodule : vc_wrr_scheduler
